// File: rtl/fb_scheduler.sv
// Frame-buffer scheduler: shares one single-port RAM between 2x-upscaled VGA
// scan-out reads and camera writes, double-buffering two frames.
module fb_scheduler #(
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 18
) (
  input  logic              vga_clk,
  input  logic              rst,
  input  logic [11:0]       x_poi,
  input  logic [11:0]       y_poi,
  input  logic              wr_req,
  input  logic [ADDR_W-2:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              wr_frame_done,
  output logic              swap_pending,
  output logic              wr_bank,
  output logic              wr_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid
);

  localparam int OFF_W = ADDR_W - 1;
  localparam logic [OFF_W-1:0] FB_SIZE = OFF_W'(FB_W * FB_H);

  logic             disp_bank;
  logic             active;
  logic             read_slot;
  logic             boundary;
  logic             in_range;
  logic [10:0]      row;
  logic [10:0]      col;
  logic [OFF_W-1:0] rd_off;
  logic [1:0]       act_d;
  logic [1:0]       rd_d;

  assign active = (x_poi >= 12'd144) && (x_poi <= 12'd783) &&
                  (y_poi >= 12'd35)  && (y_poi <= 12'd514);
  // 144 is even, so hx[0] equals x_poi[0]
  assign read_slot = active && !x_poi[0];
  assign boundary  = (x_poi == 12'd799) && (y_poi == 12'd524);

  assign row    = 11'((y_poi - 12'd35) >> 1);
  assign col    = 11'((x_poi - 12'd144) >> 1);
  assign rd_off = OFF_W'(row) * OFF_W'(FB_W) + OFF_W'(col);

  assign in_range = (wr_addr < FB_SIZE);
  assign wr_bank  = ~disp_bank;

  // Write handshake: wr_req/wr_addr/wr_data stay stable until wr_ack is high
  // at a clock edge; that edge completes the transfer and the requester may
  // advance. Out-of-range writes complete too, but never reach the RAM.
  assign wr_ack = wr_req && !read_slot && !swap_pending;

  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wr_err    <= 1'b0;
    end else begin
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      if (read_slot) begin
        ram_en   <= 1'b1;
        ram_addr <= {disp_bank, rd_off};
      end else if (wr_ack) begin
        if (in_range) begin
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= {wr_bank, wr_addr};
          ram_wdata <= wr_data;
        end else begin
          wr_err <= 1'b1;
        end
      end
    end
  end

  // A done pulse on the boundary cycle itself swaps at once, never pending
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      disp_bank    <= 1'b0;
      swap_pending <= 1'b0;
    end else if (boundary && (swap_pending || wr_frame_done)) begin
      disp_bank    <= ~disp_bank;
      swap_pending <= 1'b0;
    end else if (wr_frame_done) begin
      swap_pending <= 1'b1;
    end
  end

  // pix_data reloads only after an even-column read, holding it for 2 cycles
  always_ff @(posedge vga_clk or posedge rst) begin
    if (rst) begin
      act_d     <= '0;
      rd_d      <= '0;
      pix_valid <= 1'b0;
      pix_data  <= '0;
    end else begin
      act_d     <= {act_d[0], active};
      rd_d      <= {rd_d[0], read_slot};
      pix_valid <= act_d[1];
      if (!act_d[1])
        pix_data <= '0;
      else if (rd_d[1])
        pix_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_fb_scheduler.sv
// Bench for fb_scheduler: directed scan scenarios plus randomized camera
// traffic, compared against a coordinate-level reference model.
module tb_fb_scheduler;

  localparam int DW      = 12;
  localparam int AW      = 18;
  localparam int FB_SIZE = 320 * 240;
  localparam int BANK    = 1 << (AW - 1);

  logic          vga_clk = 1'b0;
  logic          rst = 1'b0;
  logic [11:0]   x_poi = '0;
  logic [11:0]   y_poi = '0;
  logic          wr_req = 1'b0;
  logic [AW-2:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          wr_frame_done = 1'b0;
  logic          swap_pending;
  logic          wr_bank;
  logic          wr_err;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic [DW-1:0] pix_data;
  logic          pix_valid;

  fb_scheduler dut (
    .vga_clk(vga_clk), .rst(rst), .x_poi(x_poi), .y_poi(y_poi),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_frame_done(wr_frame_done), .swap_pending(swap_pending),
    .wr_bank(wr_bank), .wr_err(wr_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .pix_data(pix_data), .pix_valid(pix_valid)
  );

  // clock / RAM
  always #5 vga_clk = ~vga_clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always @(posedge vga_clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  // scoreboard state
  int n_vec = 0;
  int n_bad = 0;
  logic [DW:0] exp_q[$];

  int            m_disp, m_pend, m_err;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;

  logic          rq_on = 1'b0;
  logic          rq_en = 1'b0;
  logic [AW-2:0] rq_addr = '0;
  logic [DW-1:0] rq_data = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at x=%0d y=%0d", tag, got, exp, x_poi, y_poi);
    end
  endtask

  task automatic model_reset();
    m_disp = 0; m_pend = 0; m_err = 0;
    e_addr = '0; e_wdata = '0;
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_pix_data", pix_data, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_swap_pending", swap_pending, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_wr_bank", wr_bank, 1);
    repeat (2) @(posedge vga_clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // one scan cycle: drive, check grant, predict, clock, check registered outputs
  task automatic cycle(input int x, input int y, input logic done);
    logic act, rd, ack_e, e_en, e_we;
    int pix_idx;
    logic [DW:0] p;
    if (!rq_on && rq_en && $urandom_range(0, 3) == 0) begin
      rq_on   = 1'b1;
      rq_addr = ($urandom_range(0, 63) == 0) ? (AW-1)'(FB_SIZE + $urandom_range(0, 50))
                                             : (AW-1)'($urandom_range(0, FB_SIZE - 1));
      rq_data = DW'($urandom);
    end
    x_poi = 12'(x); y_poi = 12'(y);
    wr_req = rq_on; wr_addr = rq_addr; wr_data = rq_data;
    wr_frame_done = done;

    act   = (x >= 144) && (x <= 783) && (y >= 35) && (y <= 514);
    rd    = act && ((x - 144) % 2 == 0);
    ack_e = rq_on && !rd && (m_pend == 0);
    #1;
    chk("wr_ack", wr_ack, ack_e);

    e_en = 1'b0; e_we = 1'b0;
    pix_idx = m_disp * BANK + ((y - 35) / 2) * 320 + (x - 144) / 2;
    if (rd) begin
      e_en = 1'b1;
      e_addr = AW'(pix_idx);
    end else if (ack_e) begin
      if (rq_addr < FB_SIZE) begin
        e_en = 1'b1; e_we = 1'b1;
        e_addr = AW'((1 - m_disp) * BANK + rq_addr);
        e_wdata = rq_data;
      end else begin
        m_err = 1;
      end
    end
    p = act ? {1'b1, mem[pix_idx]} : '0;
    exp_q.push_back(p);
    if (x == 799 && y == 524 && (m_pend != 0 || done)) begin
      m_disp = 1 - m_disp; m_pend = 0;
    end else if (done) begin
      m_pend = 1;
    end
    if (ack_e) rq_on = 1'b0;

    @(posedge vga_clk);
    #1;
    wr_frame_done = 1'b0;
    chk("ram_en", ram_en, e_en);
    if (e_en) chk("ram_we", ram_we, e_we);
    chk("ram_addr", ram_addr, e_addr);
    chk("ram_wdata", ram_wdata, e_wdata);
    chk("swap_pending", swap_pending, m_pend);
    chk("wr_bank", wr_bank, 1 - m_disp);
    chk("wr_err", wr_err, m_err);
    p = exp_q.pop_front();
    chk("pix_valid", pix_valid, p[DW]);
    chk("pix_data", pix_data, p[DW-1:0]);
  endtask

  task automatic line(input int y, input int x0, input int done_x);
    for (int x = x0; x < 800; x++) cycle(x, y, x == done_x);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] <= DW'($urandom);
    mem[0] <= 12'hABC;
    mem[1] <= 12'h123;
    #2;
    do_reset();

    // first active line: read addresses, pixel repeat, blocked then granted write
    for (int x = 0; x < 800; x++) begin
      if (x == 144) begin
        rq_on = 1'b1; rq_addr = 17'd5; rq_data = 12'h0F0;
      end
      cycle(x, 35, 1'b0);
      if (x == 144) chk("rd_addr_first", ram_addr, 18'h00000);
      if (x == 145) begin
        chk("wr_addr_5", ram_addr, 18'h20005);
        chk("wr_we_5", ram_we, 1);
        chk("wr_data_5", ram_wdata, 12'h0F0);
      end
      if (x == 146) chk("rd_addr_second", ram_addr, 18'h00001);
      if (x == 146 || x == 147) chk("pix_abc", pix_data, 12'hABC);
      if (x == 148 || x == 149) chk("pix_123", pix_data, 12'h123);
      if (x == 786) chk("pix_off_valid", pix_valid, 0);
    end
    for (int x = 0; x < 800; x++) begin
      cycle(x, 36, 1'b0);
      if (x == 782) chk("rd_addr_eol", ram_addr, 18'h0013F);
    end

    // swap requested mid-frame: writes blocked until the boundary
    rq_en = 1'b1;
    line(100, 0, 10);
    chk("pending_set", swap_pending, 1);
    line(300, 0, -1);
    line(524, 0, -1);
    chk("swap_bank", wr_bank, 0);
    for (int x = 0; x < 800; x++) begin
      cycle(x, 35, 1'b0);
      if (x == 144) chk("rd_bank1", ram_addr[AW-1], 1);
    end

    // reset mid-line with a request in flight
    rq_en = 1'b0;
    for (int x = 0; x < 300; x++) cycle(x, 40, 1'b0);
    rq_on = 1'b1; rq_addr = 17'd77; rq_data = 12'h555;
    do_reset();
    for (int x = 144; x < 800; x++) begin
      cycle(x, 40, 1'b0);
      if (x == 144) chk("rd_bank0_after_rst", ram_addr[AW-1], 0);
    end

    // done pulse exactly on the boundary cycle
    line(524, 0, 799);
    chk("boundary_swap", wr_bank, 0);

    // out-of-range write in blanking
    for (int x = 0; x < 800; x++) begin
      if (x == 100) begin
        rq_on = 1'b1; rq_addr = 17'(FB_SIZE); rq_data = 12'hFFF;
      end
      cycle(x, 520, 1'b0);
      if (x == 100) chk("oor_dropped", ram_en, 0);
    end
    chk("oor_err_sticky", wr_err, 1);

    // randomized traffic
    rq_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      int y;
      y = ($urandom_range(0, 3) == 0) ? 524 : $urandom_range(0, 524);
      line(y, 0, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 799) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
